// File: rtl/game_pkg.sv
// Shared game constants: position format {X[18:9], Y[8:0]}, slot count default,
// fire FSM state encoding and small position field helpers.
package game_pkg;

  localparam int POS_W                 = 19;
  localparam int X_W                   = 10;
  localparam int Y_W                   = 9;
  localparam int DEF_MAX_PLAYER_BULLET = 15;

  // Field slices inside a packed position word
  localparam int X_MSB = 18;
  localparam int X_LSB = 9;
  localparam int Y_MSB = 8;
  localparam int Y_LSB = 0;

  typedef enum logic [0:0] {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } fire_state_e;

  // Extract the Y field of a position word
  function automatic logic [Y_W-1:0] pos_y(input logic [POS_W-1:0] p);
    return p[Y_MSB:Y_LSB];
  endfunction

  // Replace the Y field of a position word, keeping X
  function automatic logic [POS_W-1:0] pos_with_y(input logic [POS_W-1:0] p,
                                                  input logic [Y_W-1:0]   y);
    return {p[X_MSB:X_LSB], y};
  endfunction

endpackage

// File: rtl/free_slot_finder.sv
// Combinational lowest-index priority encoder over a free-slot vector.
module free_slot_finder #(
  parameter int N     = 15,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_Free,
  output logic [IDX_W-1:0] o_Index,
  output logic             o_Found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    o_Index = {IDX_W{1'b0}};
    o_Found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_Free[k]) begin
        o_Index = IDX_W'(k);
        o_Found = 1'b1;
      end else begin
        o_Index = o_Index;
      end
    end
  end

endmodule

// File: rtl/player_bullet_pool.sv
// Player bullet pool: fixed set of bullet slots, fire FSM with per-frame
// cooldown, upward movement per frame tick and per-slot hit kills.
// Optional shot statistics counter enabled by defining BULLET_POOL_STATS_EN.
module player_bullet_pool
  import game_pkg::*;
#(
  parameter int MAX_PLAYER_BULLET = DEF_MAX_PLAYER_BULLET,
  parameter int FIRE_COOLDOWN     = 8,
  parameter int BULLET_SPEED      = 1
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Reset,
  input  logic                                 i_FrameTick,
  input  logic                                 i_Fire,
  input  logic [POS_W-1:0]                     i_PlayerPosition,
  input  logic [MAX_PLAYER_BULLET-1:0]         i_HitMask,
  output logic [MAX_PLAYER_BULLET-1:0]         o_PlayerBulletState,
  output logic [POS_W*MAX_PLAYER_BULLET-1:0]   o_PlayerBulletPosition,
  output logic                                 o_FireAccepted,
  output logic                                 o_Full
`ifdef BULLET_POOL_STATS_EN
  ,
  output logic [15:0]                          o_ShotCount
`endif
);

  localparam int IDX_W = (MAX_PLAYER_BULLET > 1) ? $clog2(MAX_PLAYER_BULLET) : 1;
  localparam int CD_W  = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
  localparam logic [Y_W-1:0]  SPEED_Y = Y_W'(BULLET_SPEED);

  logic [MAX_PLAYER_BULLET-1:0] r_state;
  logic [MAX_PLAYER_BULLET-1:0] w_state_next;
  logic [POS_W-1:0]             r_pos      [MAX_PLAYER_BULLET];
  logic [POS_W-1:0]             w_pos_next [MAX_PLAYER_BULLET];
  logic                         r_fire_accepted;
  logic                         r_full;
  fire_state_e                  r_fire_state;
  fire_state_e                  w_fire_state_next;
  logic [CD_W-1:0]              r_cd;
  logic [CD_W-1:0]              w_cd_next;
  logic                         w_accept;
  logic [IDX_W-1:0]             w_idx;
  logic                         w_found;

  // Free slots are judged on start-of-cycle state only, so same-cycle kills are not reused
  free_slot_finder #(
    .N     (MAX_PLAYER_BULLET),
    .IDX_W (IDX_W)
  ) u_finder (
    .i_Free  (~r_state),
    .o_Index (w_idx),
    .o_Found (w_found)
  );

  // Fire FSM state and cooldown counter registers
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_fire_state <= ST_READY;
      r_cd         <= {CD_W{1'b0}};
    end else begin
      r_fire_state <= w_fire_state_next;
      r_cd         <= w_cd_next;
    end
  end

  // Fire FSM next state; a zero cooldown never leaves READY
  always_comb begin
    w_fire_state_next = r_fire_state;
    case (r_fire_state)
      ST_READY: begin
        if (i_FrameTick && i_Fire && w_found && (FIRE_COOLDOWN != 0)) begin
          w_fire_state_next = ST_COOLDOWN;
        end else begin
          w_fire_state_next = ST_READY;
        end
      end
      ST_COOLDOWN: begin
        if (i_FrameTick && (r_cd <= CD_ONE)) begin
          w_fire_state_next = ST_READY;
        end else begin
          w_fire_state_next = ST_COOLDOWN;
        end
      end
      default: w_fire_state_next = ST_READY;
    endcase
  end

  // Fire FSM outputs: shot acceptance and cooldown counter update
  always_comb begin
    w_accept  = 1'b0;
    w_cd_next = r_cd;
    case (r_fire_state)
      ST_READY: begin
        if (i_FrameTick && i_Fire && w_found) begin
          w_accept  = 1'b1;
          w_cd_next = CD_LOAD;
        end else begin
          w_accept  = 1'b0;
        end
      end
      ST_COOLDOWN: begin
        if (i_FrameTick && (r_cd != {CD_W{1'b0}})) begin
          w_cd_next = r_cd - CD_ONE;
        end else begin
          w_cd_next = r_cd;
        end
      end
      default: w_cd_next = {CD_W{1'b0}};
    endcase
  end

  // Per-slot update: hit kill beats movement; allocation only into a start-of-cycle free slot
  always_comb begin
    w_state_next = r_state;
    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
      w_pos_next[k] = r_pos[k];
    end
    for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
      if (r_state[k]) begin
        if (i_HitMask[k]) begin
          w_state_next[k] = 1'b0;
        end else if (i_FrameTick) begin
          if (pos_y(r_pos[k]) >= SPEED_Y) begin
            w_pos_next[k] = pos_with_y(r_pos[k], pos_y(r_pos[k]) - SPEED_Y);
          end else begin
            w_state_next[k] = 1'b0;
          end
        end else begin
          w_state_next[k] = 1'b1;
        end
      end else if (w_accept && (w_idx == IDX_W'(k))) begin
        w_state_next[k] = 1'b1;
        w_pos_next[k]   = i_PlayerPosition;
      end else begin
        w_state_next[k] = 1'b0;
      end
    end
  end

  // Slot registers plus registered pulse and full flag
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state         <= {MAX_PLAYER_BULLET{1'b0}};
      r_fire_accepted <= 1'b0;
      r_full          <= 1'b0;
      for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
        r_pos[k] <= {POS_W{1'b0}};
      end
    end else begin
      r_state         <= w_state_next;
      r_fire_accepted <= w_accept;
      r_full          <= &w_state_next;
      for (int k = 0; k < MAX_PLAYER_BULLET; k++) begin
        r_pos[k] <= w_pos_next[k];
      end
    end
  end

  for (genvar g = 0; g < MAX_PLAYER_BULLET; g++) begin : g_pack
    assign o_PlayerBulletPosition[g*POS_W +: POS_W] = r_pos[g];
  end

  assign o_PlayerBulletState = r_state;
  assign o_FireAccepted      = r_fire_accepted;
  assign o_Full              = r_full;

`ifdef BULLET_POOL_STATS_EN
  logic [15:0] r_shot_count;

  // Saturating count of accepted shots
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_shot_count <= 16'h0000;
    end else if (w_accept && (r_shot_count != 16'hFFFF)) begin
      r_shot_count <= r_shot_count + 16'h0001;
    end else begin
      r_shot_count <= r_shot_count;
    end
  end

  assign o_ShotCount = r_shot_count;
`endif

endmodule

// File: doc/player_bullet_pool.md
PLAYER_BULLET_POOL -- requirements
Module: player_bullet_pool

Interface
REQ-001 SHALL provide parameter MAX_PLAYER_BULLET, default 15, number of bullet slots.
REQ-002 SHALL provide parameter FIRE_COOLDOWN, default 8, frames between accepted shots.
REQ-003 SHALL provide parameter BULLET_SPEED, default 1, Y pixels moved per frame.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 i_Clk  input  1  system clock; all state on rising edge.
REQ-006 i_Reset  input  1  asynchronous active-high reset.
REQ-007 i_FrameTick  input  1  one-cycle pulse per video frame.
REQ-008 i_Fire  input  1  player fire button, level, sampled only on i_FrameTick.
REQ-009 i_PlayerPosition  input  19  {X[18:9], Y[8:0]} of player muzzle.
REQ-010 i_HitMask  input  MAX_PLAYER_BULLET  per-slot collision kill request, any cycle.
REQ-011 o_PlayerBulletState  output  MAX_PLAYER_BULLET  slot active flags.
REQ-012 o_PlayerBulletPosition  output  19*MAX_PLAYER_BULLET  packed; slot k at [19k+18:19k], format {X,Y}.
REQ-013 o_FireAccepted  output  1  one-cycle pulse when a shot is allocated.
REQ-014 o_Full  output  1  high when all slots active.

Function
REQ-015 All outputs SHALL be registered; state and position changes visible the cycle after the triggering edge.
REQ-016 On i_FrameTick, each active slot with Y >= BULLET_SPEED SHALL set Y to Y - BULLET_SPEED, X unchanged.
REQ-017 On i_FrameTick, each active slot with Y < BULLET_SPEED SHALL be freed (no wrap-around, no underflow).
REQ-018 Fire FSM SHALL have states READY and COOLDOWN; reset state READY.
REQ-019 READY: on i_FrameTick with i_Fire=1 and a free slot, SHALL allocate the lowest-index free slot with position i_PlayerPosition, pulse o_FireAccepted, load cooldown counter with FIRE_COOLDOWN, go to COOLDOWN.
REQ-020 READY with i_Fire=1 and no free slot SHALL drop the request, stay READY, no pulse.
REQ-021 COOLDOWN: counter SHALL decrement once per i_FrameTick; at value 1 with tick, return to READY; i_Fire ignored.
REQ-022 FIRE_COOLDOWN=0 SHALL keep FSM in READY (one shot per frame max).
REQ-023 Free-slot search SHALL use slot state at start of the cycle; a slot freed in the same cycle is not reusable until the next tick.
REQ-024 i_HitMask[k]=1 SHALL free slot k next cycle, with priority over movement on the same cycle.
REQ-025 i_HitMask bits on inactive slots SHALL be ignored.
REQ-026 Newly allocated bullet SHALL not move on its allocation tick.
REQ-027 Positions of inactive slots SHALL hold their last value (don't-care to consumers).
REQ-028 o_Full SHALL equal AND of o_PlayerBulletState.

Reset
REQ-029 i_Reset SHALL asynchronously clear all state flags, positions to 0, o_FireAccepted 0, o_Full 0, cooldown counter 0, FSM READY.
REQ-030 Reset mid-cooldown or with active bullets SHALL abandon them; first tick after release may fire.

Configuration
REQ-031 With BULLET_POOL_STATS_EN defined, SHALL add output o_ShotCount (16 bits), incremented per o_FireAccepted, saturating at 16'hFFFF, reset 0.
REQ-032 Without BULLET_POOL_STATS_EN, port and counter SHALL be absent; other behaviour identical.

Structure
REQ-033 Shared package game_pkg SHALL hold POS_W=19, X_W=10, Y_W=9, MAX_PLAYER_BULLET default, and position field-slice constants.
REQ-034 Sub-module free_slot_finder SHALL be a combinational lowest-index priority encoder returning index plus found flag.

Verification
REQ-035 Reset, fire on tick with player {X=100,Y=400} -> slot 0 active at Y=400, o_FireAccepted one pulse; next tick Y=399.
REQ-036 Hold i_Fire across 20 ticks, FIRE_COOLDOWN=8 -> accepts on ticks 1, 10, 19 into slots 0,1,2.
REQ-037 Bullet at Y=0 on tick -> freed, state bit 0, no wrap to 511.
REQ-038 Fill all 15 slots (FIRE_COOLDOWN=0), fire again -> no pulse, o_Full=1; i_HitMask=15'h0004 -> slot 2 freed, next fire allocates slot 2.
REQ-039 i_HitMask on slot 0 coincident with tick -> slot freed, position not updated; assert reset mid-cooldown -> all cleared immediately, FSM READY.
REQ-040 With BULLET_POOL_STATS_EN, three accepted shots -> o_ShotCount=3; forced near-max value saturates at 16'hFFFF.
